int_to_float_conv: RTL and testbench
====================================

Name: int_to_float_conv

Overview:
- Upstream operand stage for the floating-point adder. Converts a signed 32-bit two's-complement integer into the team's 32-bit float format, which the adder consumes on op_A_in/op_B_in.
- Float format: sign [31], 6-bit biased exponent [30:25], 25-bit fraction [24:0] with a hidden leading 1.
- Normalisation is iterative, one left shift per cycle. valid/ready handshakes on both sides.
- Status codes match the adder: 0 exact, 3 inexact.

Parameters:
- EXP_BIAS, 31, exponent bias; legal range 0..31, so the exponent never exceeds 62.

Ports:
- clock_100kHz  in  1  system clock
- reset  in  1  asynchronous, active-low
- int_in  in  32  signed integer operand
- in_valid  in  1  int_in valid
- in_ready  out  1  block can accept an operand
- data_out  out  32  converted float
- status_out  out  4  0 exact, 3 inexact (truncated bits nonzero)
- out_valid  out  1  data_out/status_out valid
- out_ready  in  1  consumer accepts the result
- qual_lugar  out  3  current state code (debug)

Behaviour:
- Reset values (reset low, asynchronous):
  - state IDLE; data_out, status_out, out_valid and qual_lugar = 0; in_ready = 1.
  - Internal registers (sign, mag[31:0], cnt[4:0]) = 0.
  - Reset asserted in any state, including mid-NORMALIZE, aborts the conversion with no output.
- Handshakes:
  - Input transfer happens on the clock edge where in_valid & in_ready.
  - Output transfer happens on the clock edge where out_valid & out_ready.
- IDLE (qual_lugar 0):
  - in_ready = 1.
  - On input transfer: sign <= int_in[31], mag <= int_in, go ABS.
- ABS (qual_lugar 1):
  - in_ready = 0.
  - mag <= sign ? (~mag + 1) : mag, taken mod 2^32. -2^31 therefore yields 0x80000000, which is the correct unsigned magnitude.
  - cnt <= 0.
  - If mag == 0, go PACK with a zero flag set; otherwise go NORMALIZE.
- NORMALIZE (qual_lugar 2):
  - If mag[31] == 1, go PACK.
  - Otherwise mag <= mag << 1 and cnt <= cnt + 1.
  - Exactly one shift per cycle; cnt ends equal to the leading-zero count lz (0..31).
- PACK (qual_lugar 3):
  - Zero flag set: data_out <= 0, status_out <= 0.
  - Otherwise:
    - data_out[31] <= sign
    - data_out[30:25] <= EXP_BIAS + 31 - cnt (6-bit)
    - data_out[24:0] <= mag[30:6] (truncation, round toward zero)
    - status_out <= (mag[5:0] != 0) ? 3 : 0
  - Go DONE.
- DONE (qual_lugar 4):
  - out_valid = 1.
  - data_out and status_out are held stable while out_ready = 0; in_valid is ignored.
  - On output transfer: out_valid <= 0, go IDLE.
  - No back-to-back accept: in_ready rises only in IDLE, one cycle after the output transfer.
- Latency, counting the input-transfer edge as edge 0:
  - Nonzero operand: out_valid is high after edge lz+3.
  - Zero operand: out_valid is high after edge 2.
- Throughput: at most one conversion in flight.
- Unused state encodings return to IDLE on the next clock edge.

Test Plan:
- int_in = 0x00000001 (lz 31) -> data_out 0x3E000000, status 0, out_valid after edge 34.
- int_in = 0xFFFFFFFA (-6) -> data_out 0xC3000000, status 0, out_valid after edge 32.
- int_in = 0x00000000 -> data_out 0x00000000, status 0, out_valid after edge 2, sign 0.
- int_in = 0x7FFFFFFF -> data_out 0x7BFFFFFF, status 3 (inexact). int_in = 0x80000000 -> data_out 0xFC000000, status 0, out_valid after edge 3.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid while toggling in_valid and int_in -> data_out, status_out and out_valid stay stable, in_ready stays 0, no new operand is captured. Release out_ready -> IDLE on the next edge, in_ready = 1.
- Reset mid-operation: assert reset during NORMALIZE of 0x00000001 -> outputs 0 immediately (asynchronous), in_ready = 1. A following conversion of 0x00000006 -> data_out 0x43000000, status 0.

Source files
------------

// File: rtl/int_to_float_conv_if.sv
// Operand/result handshake bundle for int_to_float_conv.
// The master is the producer/consumer side and the slave is the converter.
`timescale 1ns/1ps
interface int_to_float_conv_if;
    logic [31:0] int_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output int_in, in_valid, out_ready,
        input  in_ready, data_out, status_out, out_valid
    );

    modport slave (
        input  int_in, in_valid, out_ready,
        output in_ready, data_out, status_out, out_valid
    );
endinterface

// File: rtl/int_to_float_conv.sv
// Signed 32-bit integer to float (sign | 6-bit biased exponent | 25-bit fraction) converter.
// It normalises iteratively with one left shift per cycle, and it holds one conversion at a time.
`timescale 1ns/1ps
module int_to_float_conv #(
    parameter int EXP_BIAS = 31
) (
    input  logic                 clock_100kHz,
    input  logic                 reset,
    int_to_float_conv_if.slave   bus,
    output logic [2:0]           qual_lugar
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_NORM = 3'd2,
        S_PACK = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // The exponent is (bias + 31 - leading_zeros), so the constant part folds into one term.
    localparam logic [5:0] EXP_TOP = 6'(EXP_BIAS + 31);

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic        r_zero;
    logic [31:0] r_mag;
    logic [4:0]  r_cnt;
    logic [31:0] r_data_out;
    logic [3:0]  r_status_out;

    // NOTE: state-holding processes use non-blocking (<=) so all registers update together at the edge.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid)   w_next = S_ABS;
            S_ABS:  w_next = (r_mag == 32'd0) ? S_PACK : S_NORM;
            S_NORM: if (r_mag[31])      w_next = S_PACK;
            S_PACK: w_next = S_DONE;
            S_DONE: if (bus.out_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_sign       <= 1'b0;
            r_zero       <= 1'b0;
            r_mag        <= 32'd0;
            r_cnt        <= 5'd0;
            r_data_out   <= 32'd0;
            r_status_out <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= bus.int_in[31];
                        r_mag  <= bus.int_in;
                    end
                end
                S_ABS: begin
                    // Negating -2^31 wraps back to 0x80000000, which is the correct unsigned magnitude.
                    r_mag  <= r_sign ? (~r_mag + 32'd1) : r_mag;
                    r_cnt  <= 5'd0;
                    r_zero <= (r_mag == 32'd0);
                end
                S_NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_PACK: begin
                    if (r_zero) begin
                        r_data_out   <= 32'd0;
                        r_status_out <= 4'd0;
                    end else begin
                        r_data_out   <= {r_sign, EXP_TOP - {1'b0, r_cnt}, r_mag[30:6]};
                        r_status_out <= (r_mag[5:0] != 6'd0) ? 4'd3 : 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.data_out   = r_data_out;
    assign bus.status_out = r_status_out;
    assign qual_lugar     = r_state;

endmodule

// File: tb/tb_int_to_float_conv.sv
// Directed-vector bench for int_to_float_conv, with expected values computed by hand.
// Inputs change right after posedge and outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_int_to_float_conv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] qual_lugar;
    int         n_vec = 0;
    int         n_err = 0;

    int_to_float_conv_if bus ();

    int_to_float_conv #(.EXP_BIAS(31)) dut (
        .clock_100kHz (clk),
        .reset        (rst_n),
        .bus          (bus),
        .qual_lugar   (qual_lugar)
    );

    always #5000 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // This task applies one operand and waits for the result while checking latency.
    // It can hold out_ready low for `hold` cycles before it accepts the result.
    task automatic convert(input string tag, input logic [31:0] val,
                           input logic [31:0] exp_data, input logic [3:0] exp_stat,
                           input int exp_lat, input int hold);
        int  n;
        bit  seen;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.int_in   = val;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.int_in   = ~val;
        @(negedge clk);
        check({tag, " state abs"}, 32'(qual_lugar), 32'd1);
        check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " data"}, bus.data_out, exp_data);
        check({tag, " status"}, 32'(bus.status_out), 32'(exp_stat));
        check({tag, " state done"}, 32'(qual_lugar), 32'd4);
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.int_in   = $urandom;
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold data"}, bus.data_out, exp_data);
            check({tag, " hold status"}, 32'(bus.status_out), 32'(exp_stat));
            check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
        check({tag, " state idle"}, 32'(qual_lugar), 32'd0);
    endtask

    initial begin
        bus.int_in    = 32'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        #2000;
        check("rst data_out", bus.data_out, 32'd0);
        check("rst status_out", 32'(bus.status_out), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst qual_lugar", 32'(qual_lugar), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("one",    32'h0000_0001, 32'h3E00_0000, 4'd0, 34, 0);
        convert("neg6",   32'hFFFF_FFFA, 32'hC300_0000, 4'd0, 32, 0);
        convert("zero",   32'h0000_0000, 32'h0000_0000, 4'd0, 2,  0);
        convert("maxpos", 32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'd3, 4,  5);
        convert("minneg", 32'h8000_0000, 32'hFC00_0000, 4'd0, 3,  0);
        convert("maxpos2", 32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'd3, 4, 0);

        // The reset lands during NORMALIZE of 0x1, while data_out still holds the previous result.
        @(negedge clk);
        bus.int_in   = 32'h0000_0001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        check("mid state norm", 32'(qual_lugar), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async data_out", bus.data_out, 32'd0);
        check("async status_out", 32'(bus.status_out), 32'd0);
        check("async out_valid", 32'(bus.out_valid), 32'd0);
        check("async qual_lugar", 32'(qual_lugar), 32'd0);
        check("async in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post rst no output", 32'(bus.out_valid), 32'd0);
        end

        convert("six", 32'h0000_0006, 32'h4300_0000, 4'd0, 32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
